// File: rtl/shiftreg_ctrl.sv
// shiftreg_ctrl: flow-control wrapper around an external DEPTH-stage shift register.
// The register only advances when a sample can enter and leave together, so the
// delay it applies is exactly DEPTH accepted samples. A flush pads the pipe with
// zeros (ALIGN) until the oldest held sample reaches the tap, then drains the
// held samples out under downstream backpressure (DRAIN).
module shiftreg_ctrl #(
    parameter int DEPTH = 20000,
    parameter int W     = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    input  logic          flush,
    output logic          sr_shift_en,
    output logic [W-1:0]  sr_data_in,
    input  logic [W-1:0]  sr_data_out,
    output logic [CW-1:0] level,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_ALIGN,
        S_DRAIN
    } state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    state_t        state, state_nxt;
    logic [CW-1:0] level_nxt;
    logic [CW-1:0] gap, gap_nxt;
    logic [CW-1:0] rem, rem_nxt;

    // Counters saturate so a malformed sequence can never wrap them.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v >= DEPTH_C) ? DEPTH_C : v + ONE_C;
    endfunction

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        return (v == '0) ? '0 : v - ONE_C;
    endfunction

    // Next-state, counter updates and handshake/shift outputs.
    always_comb begin
        state_nxt   = state;
        level_nxt   = level;
        gap_nxt     = gap;
        rem_nxt     = rem;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        sr_shift_en = 1'b0;
        sr_data_in  = '0;

        case (state)
            S_IDLE: begin
                // flush is deliberately ignored here: nothing is held yet.
                in_ready   = 1'b1;
                sr_data_in = in_data;
                if (in_valid) begin
                    sr_shift_en = 1'b1;
                    level_nxt   = ONE_C;
                    state_nxt   = S_FILL;
                end
            end

            S_FILL: begin
                sr_data_in = in_data;
                if (flush) begin
                    // Zero-pad until the oldest held sample sits at the last stage.
                    gap_nxt   = DEPTH_C - level;
                    state_nxt = S_ALIGN;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        sr_shift_en = 1'b1;
                        level_nxt   = sat_inc(level);
                        if (level_nxt == DEPTH_C) begin
                            state_nxt = S_RUN;
                        end
                    end
                end
            end

            S_RUN: begin
                sr_data_in = in_data;
                if (flush) begin
                    rem_nxt   = DEPTH_C;
                    state_nxt = S_DRAIN;
                end else begin
                    // Advance only on a paired input+output transfer so level stays DEPTH.
                    out_valid = 1'b1;
                    in_ready  = out_ready;
                    if (in_valid && out_ready) begin
                        sr_shift_en = 1'b1;
                    end
                end
            end

            S_ALIGN: begin
                sr_shift_en = 1'b1;
                gap_nxt     = sat_dec(gap);
                if (gap_nxt == '0) begin
                    rem_nxt   = level;
                    state_nxt = S_DRAIN;
                end
            end

            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    sr_shift_en = 1'b1;
                    level_nxt   = sat_dec(level);
                    rem_nxt     = sat_dec(rem);
                    if (rem_nxt == '0) begin
                        state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Handshakes and shifting are suppressed for the whole reset window.
        if (rst) begin
            in_ready    = 1'b0;
            out_valid   = 1'b0;
            sr_shift_en = 1'b0;
        end
    end

    // State and counter registers; reset abandons any held samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            level <= '0;
            gap   <= '0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            gap   <= gap_nxt;
            rem   <= rem_nxt;
        end
    end

    assign out_data = sr_data_out;
    assign busy     = (state == S_ALIGN) || (state == S_DRAIN);

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Bench for shiftreg_ctrl with DEPTH=4, W=8 and a behavioural shift register.
module tb_shiftreg_ctrl;

    localparam int DEPTH = 4;
    localparam int W     = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          flush;
    logic          sr_shift_en;
    logic [W-1:0]  sr_data_in;
    logic [W-1:0]  sr_data_out;
    logic [CW-1:0] level;
    logic          busy;

    logic [W-1:0]  sr [0:DEPTH-1];
    logic [W-1:0]  sb [$];
    int            checks = 0;
    int            failures = 0;

    shiftreg_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .flush(flush),
        .sr_shift_en(sr_shift_en), .sr_data_in(sr_data_in), .sr_data_out(sr_data_out),
        .level(level), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural shift register driven by the controller.
    always @(posedge clk) begin
        if (sr_shift_en) begin
            for (int i = DEPTH - 1; i > 0; i--) sr[i] <= sr[i-1];
            sr[0] <= sr_data_in;
        end
    end
    assign sr_data_out = sr[DEPTH-1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || sr_shift_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: in_ready=%b out_valid=%b sr_shift_en=%b required 0/0/0",
                         in_ready, out_valid, sr_shift_en);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== '0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: level=%0d busy=%b in_ready=%b out_valid=%b required 0/0/1/0",
                     level, busy, in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fill(input logic [W-1:0] d0, input logic [W-1:0] d1,
                             input logic [W-1:0] d2, input logic [W-1:0] d3);
        logic [W-1:0] vals [4];
        vals[0] = d0; vals[1] = d1; vals[2] = d2; vals[3] = d3;
        out_ready = 1'b0; flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || sr_shift_en !== 1'b1 || sr_data_in !== vals[i]) begin
                failures++;
                $display("FAIL fill_hs[%0d]: in_ready=%b out_valid=%b shift=%b sr_in=%h required 1/0/1/%h",
                         i, in_ready, out_valid, sr_shift_en, sr_data_in, vals[i]);
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            @(posedge clk); #1;
            checks++;
            if (level !== CW'(i + 1)) begin
                failures++;
                $display("FAIL fill_level[%0d]: level=%0d required %0d", i, level, i + 1);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== d0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_run: out_valid=%b out_data=%h in_ready=%b busy=%b required 1/%h/0/0",
                     out_valid, out_data, in_ready, busy, d0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_run_passthrough();
        logic [W-1:0] exp_d;
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || sr_shift_en !== 1'b1) begin
            failures++;
            $display("FAIL run_pair_hs: in_ready=%b out_valid=%b shift=%b required 1/1/1",
                     in_ready, out_valid, sr_shift_en);
        end
        if (out_valid && out_ready) begin
            exp_d = sb.pop_front();
            checks++;
            if (out_data !== exp_d) begin
                failures++;
                $display("FAIL run_pair_data: out_data=%h required %h", out_data, exp_d);
            end
        end
        if (in_valid && in_ready) sb.push_back(in_data);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_data !== 8'h22 || level !== CW'(DEPTH) || sr_shift_en !== 1'b0) begin
            failures++;
            $display("FAIL run_next: out_data=%h level=%0d shift=%b required 22/%0d/0",
                     out_data, level, sr_shift_en, DEPTH);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_run_stall();
        in_valid = 1'b1; in_data = 8'h66; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (sr_shift_en !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h22 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall[%0d]: shift=%b in_ready=%b out_data=%h out_valid=%b required 0/0/22/1",
                         i, sr_shift_en, in_ready, out_data, out_valid);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_run_random();
        logic [W-1:0] exp_d;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = W'($urandom); out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (sr_shift_en !== out_ready || in_ready !== out_ready) begin
                failures++;
                $display("FAIL rand_hs[%0d]: shift=%b in_ready=%b required %b", i, sr_shift_en, in_ready, out_ready);
            end
            if (out_valid && out_ready) begin
                exp_d = sb.pop_front();
                checks++;
                if (out_data !== exp_d) begin
                    failures++;
                    $display("FAIL rand_data[%0d]: out_data=%h required %h", i, out_data, exp_d);
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_flush_run();
        logic       pat [5];
        logic [W-1:0] exp_d;
        int         emitted = 0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || sr_shift_en !== 1'b0) begin
            failures++;
            $display("FAIL run_flush: out_valid=%b in_ready=%b shift=%b required 0/0/0",
                     out_valid, in_ready, sr_shift_en);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'hEE; out_ready = pat[i];
            flush = (i == 1);
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1 ||
                sr_shift_en !== pat[i] || sr_data_in !== '0) begin
                failures++;
                $display("FAIL drain_hs[%0d]: busy=%b in_ready=%b out_valid=%b shift=%b sr_in=%h required 1/0/1/%b/00",
                         i, busy, in_ready, out_valid, sr_shift_en, sr_data_in, pat[i]);
            end
            if (out_valid && out_ready) begin
                emitted++;
                exp_d = sb.pop_front();
                checks++;
                if (out_data !== exp_d) begin
                    failures++;
                    $display("FAIL drain_data[%0d]: out_data=%h required %h", i, out_data, exp_d);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || level !== '0 || in_ready !== 1'b1 || emitted != 4 || sb.size() != 0) begin
            failures++;
            $display("FAIL drain_end: busy=%b level=%0d in_ready=%b emitted=%0d left=%0d required 0/0/1/4/0",
                     busy, level, in_ready, emitted, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_fill();
        logic [W-1:0] exp_d;
        int           n = 0;
        int           gap_exp = DEPTH - 2;
        out_ready = 1'b0; flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = (i == 0) ? 8'hA1 : 8'hA2;
            @(negedge clk);
            if (in_valid && in_ready) sb.push_back(in_data);
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = 8'hA3; flush = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || sr_shift_en !== 1'b0 || out_valid !== 1'b0 || level !== CW'(2)) begin
            failures++;
            $display("FAIL fill_flush: in_ready=%b shift=%b out_valid=%b level=%0d required 0/0/0/2",
                     in_ready, sr_shift_en, out_valid, level);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < gap_exp; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b1 || sr_shift_en !== 1'b1 || sr_data_in !== '0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL align[%0d]: out_valid=%b busy=%b shift=%b sr_in=%h in_ready=%b required 0/1/1/00/0",
                         i, out_valid, busy, sr_shift_en, sr_data_in, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        while (busy && n < 16) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || sr_data_in !== '0) begin
                failures++;
                $display("FAIL align_drain_hs[%0d]: out_valid=%b sr_in=%h required 1/00", n, out_valid, sr_data_in);
            end
            if (out_valid && out_ready) begin
                exp_d = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
                checks++;
                if (out_data !== exp_d) begin
                    failures++;
                    $display("FAIL align_drain_data[%0d]: out_data=%h required %h", n, out_data, exp_d);
                end
            end
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || level !== '0 || sb.size() != 0 || n != 2) begin
            failures++;
            $display("FAIL align_end: busy=%b level=%0d left=%0d drain_cycles=%0d required 0/0/0/2",
                     busy, level, sb.size(), n);
        end
    endtask

    task automatic test_rst_drain();
        logic [W-1:0] exp_d;
        test_fill(8'h11, 8'h22, 8'h33, 8'h44);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                exp_d = sb.pop_front();
                checks++;
                if (out_data !== exp_d) begin
                    failures++;
                    $display("FAIL rstdrain_data[%0d]: out_data=%h required %h", i, out_data, exp_d);
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || sr_shift_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: out_valid=%b in_ready=%b shift=%b required 0/0/0",
                     out_valid, in_ready, sr_shift_en);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (level !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || sr_shift_en !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL rst_after[%0d]: level=%0d out_valid=%b busy=%b shift=%b in_ready=%b required 0/0/0/0/1",
                         i, level, out_valid, busy, sr_shift_en, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_d;
        int           n = 0;
        test_fill(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = W'($urandom); out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (sr_shift_en !== 1'b1 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_hs[%0d]: shift=%b in_ready=%b required 1/1", i, sr_shift_en, in_ready);
            end
            if (out_valid && out_ready) begin
                exp_d = sb.pop_front();
                checks++;
                if (out_data !== exp_d) begin
                    failures++;
                    $display("FAIL b2b_data[%0d]: out_data=%h required %h", i, out_data, exp_d);
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b1;
        while (busy && n < 20) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                exp_d = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
                checks++;
                if (out_data !== exp_d) begin
                    failures++;
                    $display("FAIL b2b_drain[%0d]: out_data=%h required %h", n, out_data, exp_d);
                end
            end
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || sb.size() != 0 || level !== '0) begin
            failures++;
            $display("FAIL b2b_end: busy=%b left=%0d level=%0d required 0/0/0", busy, sb.size(), level);
        end
    endtask

    initial begin
        test_reset();
        test_fill(8'h11, 8'h22, 8'h33, 8'h44);
        test_run_passthrough();
        test_run_stall();
        test_run_random();
        test_flush_run();
        test_flush_fill();
        test_rst_drain();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
